// File: rtl/led_gradient_pkg.sv
// Shared types and the per-channel value function for the LED pattern generator.
package led_gradient_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_ROTATE  = 2'd1,
    MODE_BREATHE = 2'd2
  } mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

  // Widest compare value the helper supports; callers truncate to their width.
  localparam int unsigned ValW = 16;

  function automatic logic [ValW-1:0] chan_val(input mode_e           m,
                                               input int unsigned     idx,
                                               input logic [ValW-1:0] phase,
                                               input logic [ValW-1:0] level,
                                               input int unsigned     ctr_len);
    logic [ValW-1:0] v;
    logic [ValW-1:0] mask;
    mask = ValW'((32'd1 << ctr_len) - 32'd1);
    case (m)
      MODE_ROTATE:  v = ValW'(idx) + phase;
      MODE_BREATHE: v = level;
      default:      v = ValW'(idx);
    endcase
    return v & mask;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Prescaler for pattern steps: step is high in the cycle whose edge ends a TICK_DIV period.
module step_timer #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic step
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign step = en && (r_cnt == CntMax);

  // Counter freezes (does not clear) while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= step ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_gradient_gen.sv
// Pattern source for the LED PWM bank: static, rotating and breathing compare values.
// Optional macro LED_GRADIENT_PWM_SYNC_EN defers compare_out loads to PWM counter wraps.
module led_gradient_gen
  import led_gradient_pkg::*;
#(
  parameter int unsigned CTR_LEN  = 3,
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      dir,
  output logic [NUM_CH*CTR_LEN-1:0] compare_out,
  output logic                      step_stb
`ifdef LED_GRADIENT_PWM_SYNC_EN
  ,
  input  logic                      pwm_wrap
`endif
);

  localparam logic [CTR_LEN-1:0] LvlMax = '1;

  logic                      w_step;
  mode_e                     w_mode_in;
  mode_e                     r_mode, w_mode_d;
  logic [CTR_LEN-1:0]        r_phase, w_phase_d;
  logic [CTR_LEN-1:0]        r_level, w_level_d;
  br_state_e                 r_br, w_br_d;
  logic                      r_step_stb;
  logic [NUM_CH*CTR_LEN-1:0] r_compare;
  logic [NUM_CH*CTR_LEN-1:0] w_cmp_next;
  logic [NUM_CH*CTR_LEN-1:0] w_cmp_reset;

  step_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .step (w_step)
  );

  assign w_mode_in = (mode == 2'd3) ? MODE_STATIC : mode_e'(mode);

  always_comb begin
    w_mode_d  = r_mode;
    w_phase_d = r_phase;
    w_level_d = r_level;
    w_br_d    = r_br;
    if (w_step) begin
      w_mode_d = w_mode_in;
      case (w_mode_in)
        MODE_ROTATE: w_phase_d = dir ? r_phase - 1'b1 : r_phase + 1'b1;
        MODE_BREATHE: begin
          if (r_mode != MODE_BREATHE) begin
            w_level_d = '0;
            w_br_d    = BR_UP;
          end else if (r_br == BR_UP) begin
            // Each extreme is held for exactly one step before turning around.
            if (r_level == LvlMax) begin
              w_br_d    = BR_DOWN;
              w_level_d = LvlMax - 1'b1;
            end else begin
              w_level_d = r_level + 1'b1;
            end
          end else begin
            if (r_level == '0) begin
              w_br_d    = BR_UP;
              w_level_d = CTR_LEN'(1);
            end else begin
              w_level_d = r_level - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cmp_next  = '0;
    w_cmp_reset = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_cmp_next[i*CTR_LEN +: CTR_LEN] =
          CTR_LEN'(chan_val(w_mode_d, i, ValW'(w_phase_d), ValW'(w_level_d), CTR_LEN));
      w_cmp_reset[i*CTR_LEN +: CTR_LEN] =
          CTR_LEN'(chan_val(MODE_STATIC, i, '0, '0, CTR_LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode     <= MODE_STATIC;
      r_phase    <= '0;
      r_level    <= '0;
      r_br       <= BR_UP;
      r_step_stb <= 1'b0;
    end else begin
      r_mode     <= w_mode_d;
      r_phase    <= w_phase_d;
      r_level    <= w_level_d;
      r_br       <= w_br_d;
      r_step_stb <= w_step;
    end
  end

`ifdef LED_GRADIENT_PWM_SYNC_EN
  logic r_pend;

  // Loads use next-state so a step coinciding with a wrap is picked up at that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_compare <= w_cmp_reset;
      r_pend    <= 1'b0;
    end else if (pwm_wrap && (r_pend || w_step)) begin
      r_compare <= w_cmp_next;
      r_pend    <= 1'b0;
    end else if (w_step) begin
      r_pend    <= 1'b1;
    end
  end
`else
  // In the step_stb cycle next-state equals the freshly stepped state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_compare <= w_cmp_reset;
    end else if (r_step_stb) begin
      r_compare <= w_cmp_next;
    end
  end
`endif

  assign compare_out = r_compare;
  assign step_stb    = r_step_stb;

endmodule
